cntr_ticket_arb: RTL and testbench

CNTR_TICKET_ARB -- requirements
Module: cntr_ticket_arb

---
 rtl/cntr_ticket_pkg.sv | 18 +
 rtl/cntr.sv | 20 ++
 rtl/cntr_ticket_arb.sv | 94 +++++++++
 tb/tb_cntr_ticket_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cntr_ticket_pkg.sv
// Shared types and helpers for the ticket arbiter: FSM state encoding and
// requester-index width.
package cntr_ticket_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_REQ_CNT = 4;
    localparam int DEF_IDX_W   = idx_width(DEF_REQ_CNT);

endpackage

// File: rtl/cntr.sv
// Shared ticket counter: synchronous clear, increments by one per enable pulse,
// wrapping modulo 2^DATA_WIDTH.
module Cntr #(
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] val
);

    always_ff @(posedge clk) begin
        if (rst) begin
            val <= '0;
        end else if (en) begin
            val <= val + 1'b1;
        end
    end

endmodule

// File: rtl/cntr_ticket_arb.sv
// Round-robin ticket arbiter: grants one requester at a time, hands it the
// current shared counter value and holds the response until it is consumed.
module cntr_ticket_arb
    import cntr_ticket_pkg::*;
#(
    parameter  int DATA_WIDTH = 2,
    parameter  int REQ_CNT    = 4,
    localparam int ID_W       = idx_width(REQ_CNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [REQ_CNT-1:0]    req_vld,
    output logic [REQ_CNT-1:0]    req_rd,
    output logic                  resp_vld,
    input  logic                  resp_rd,
    output logic [ID_W-1:0]       resp_id,
    output logic [DATA_WIDTH-1:0] resp_val,
    output logic [DATA_WIDTH-1:0] cnt_val,
    output state_t                dbg_state
);

    // Handshakes: a requester holds req_vld until it sees its req_rd bit for one
    // cycle; a response is transferred on the cycle where resp_vld && resp_rd.

    state_t                r_state;
    logic [ID_W-1:0]       r_last_grant;
    logic [ID_W-1:0]       r_resp_id;
    logic [DATA_WIDTH-1:0] r_resp_val;

    logic                  w_found;
    logic [ID_W-1:0]       w_sel;
    logic                  w_accept;
    logic                  w_cnt_rst;
    logic [DATA_WIDTH-1:0] w_cnt_val;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int off = 1; off <= REQ_CNT; off++) begin
            if (!w_found && req_vld[(int'(r_last_grant) + off) % REQ_CNT]) begin
                w_found = 1'b1;
                w_sel   = ID_W'((int'(r_last_grant) + off) % REQ_CNT);
            end
        end
    end

    assign w_accept  = !rst && (r_state == IDLE) && w_found;
    assign w_cnt_rst = rst || clr;

    Cntr #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cntr (
        .clk (clk),
        .rst (w_cnt_rst),
        .en  (w_accept),
        .val (w_cnt_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= ID_W'(REQ_CNT - 1);
            r_resp_id    <= '0;
            r_resp_val   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= RESP;
                        r_last_grant <= w_sel;
                        r_resp_id    <= w_sel;
                        r_resp_val   <= w_cnt_val;
                    end
                end
                RESP: begin
                    if (resp_rd) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_rd    = w_accept ? (REQ_CNT'(1) << w_sel) : '0;
    assign resp_vld  = (r_state == RESP);
    assign resp_id   = r_resp_id;
    assign resp_val  = r_resp_val;
    assign cnt_val   = w_cnt_val;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cntr_ticket_arb.sv
// Directed bench for cntr_ticket_arb with hand-computed expectations.
module tb_cntr_ticket_arb;
  import cntr_ticket_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [3:0] req_vld;
  logic [3:0] req_rd;
  logic       resp_vld;
  logic       resp_rd;
  logic [1:0] resp_id;
  logic [1:0] resp_val;
  logic [1:0] cnt_val;
  state_t     dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cntr_ticket_arb #(.DATA_WIDTH(2), .REQ_CNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_vld   (req_vld),
    .req_rd    (req_rd),
    .resp_vld  (resp_vld),
    .resp_rd   (resp_rd),
    .resp_id   (resp_id),
    .resp_val  (resp_val),
    .cnt_val   (cnt_val),
    .dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; req_vld = 4'b0000; resp_rd = 1'b0;
    do_reset();

    // reset state
    chk("rst_resp_vld", 32'(resp_vld), 0);
    chk("rst_resp_id",  32'(resp_id),  0);
    chk("rst_resp_val", 32'(resp_val), 0);
    chk("rst_cnt_val",  32'(cnt_val),  0);
    chk("rst_req_rd",   32'(req_rd),   0);
    chk("rst_state",    32'(dbg_state), 32'(IDLE));

    // single request from requester 0
    req_vld = 4'b0001; resp_rd = 1'b1;
    #1;
    chk("single_req_rd", 32'(req_rd), 32'b0001);
    step();
    req_vld = 4'b0000;
    #1;
    chk("single_req_rd_off", 32'(req_rd),   0);
    chk("single_resp_vld",   32'(resp_vld), 1);
    chk("single_resp_id",    32'(resp_id),  0);
    chk("single_resp_val",   32'(resp_val), 0);
    chk("single_cnt_val",    32'(cnt_val),  1);
    step();
    chk("single_resp_drop",  32'(resp_vld), 0);

    // all requesting: round-robin order and counter wrap
    do_reset();
    req_vld = 4'b1111; resp_rd = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant_%0d", k), 32'(req_rd), 32'(1 << (k % 4)));
      step();
      chk($sformatf("rr_resp_vld_%0d", k), 32'(resp_vld), 1);
      chk($sformatf("rr_req_rd_busy_%0d", k), 32'(req_rd), 0);
      chk($sformatf("rr_resp_id_%0d", k),  32'(resp_id),  32'(k % 4));
      chk($sformatf("rr_resp_val_%0d", k), 32'(resp_val), 32'(k % 4));
      chk($sformatf("rr_cnt_val_%0d", k),  32'(cnt_val),  32'((k + 1) % 4));
      step();
    end

    // stalled consumer: response held stable; last_grant=0, cnt=1
    resp_rd = 1'b0;
    chk("stall_grant", 32'(req_rd), 32'b0010);
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_vld_%0d", k), 32'(resp_vld), 1);
      chk($sformatf("stall_id_%0d", k),  32'(resp_id),  1);
      chk($sformatf("stall_val_%0d", k), 32'(resp_val), 1);
      chk($sformatf("stall_rd_%0d", k),  32'(req_rd),   0);
      chk($sformatf("stall_cnt_%0d", k), 32'(cnt_val),  2);
      step();
    end
    resp_rd = 1'b1;
    step();

    // clear in same cycle as accept: cnt=2 issued, counter then 0
    chk("clr_pre_cnt", 32'(cnt_val), 2);
    clr = 1'b1;
    #1;
    chk("clr_grant", 32'(req_rd), 32'b0100);
    step();
    clr = 1'b0; resp_rd = 1'b0;
    #1;
    chk("clr_resp_val", 32'(resp_val), 2);
    chk("clr_resp_id",  32'(resp_id),  2);
    chk("clr_cnt_val",  32'(cnt_val),  0);

    // clear during RESP leaves the pending response untouched
    clr = 1'b1;
    step();
    clr = 1'b0;
    #1;
    chk("clr_resp_hold_vld", 32'(resp_vld), 1);
    chk("clr_resp_hold_val", 32'(resp_val), 2);
    chk("clr_resp_hold_id",  32'(resp_id),  2);

    // reset mid-RESP discards response; grant goes to lowest requester
    req_vld = 4'b0110; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_vld",   32'(resp_vld), 0);
    chk("rst_mid_cnt",   32'(cnt_val),  0);
    chk("rst_mid_grant", 32'(req_rd),   32'b0010);
    step();
    req_vld = 4'b0100; resp_rd = 1'b1;
    #1;
    chk("rst_mid_id",  32'(resp_id),  1);
    chk("rst_mid_val", 32'(resp_val), 0);
    step();

    // grant 2 then 1, no stale grant to 2
    chk("seq_grant2", 32'(req_rd), 32'b0100);
    step();
    req_vld = 4'b0000;
    #1;
    chk("seq_id2",  32'(resp_id),  2);
    chk("seq_val2", 32'(resp_val), 1);
    step();
    req_vld = 4'b0010;
    #1;
    chk("seq_grant1", 32'(req_rd), 32'b0010);
    step();
    req_vld = 4'b0000;
    #1;
    chk("seq_id1",  32'(resp_id),  1);
    chk("seq_val1", 32'(resp_val), 2);
    chk("seq_cnt",  32'(cnt_val),  3);
    step();

    // idle with no requests: nothing granted, counter unchanged
    step();
    chk("idle_req_rd", 32'(req_rd),   0);
    chk("idle_vld",    32'(resp_vld), 0);
    chk("idle_cnt",    32'(cnt_val),  3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
